umul_seq: RTL and testbench
===========================

Name: umul_seq

Overview:
- Sequential unsigned multiplier using shift-add, one partial product per cycle.
- Forms the inverse operation to the team's combinational unsigned divide primitive. It is used where a full-width combinational multiply is too costly in area.
- Operands are accepted over a valid/ready input channel. The 2*WIDTH-bit product is returned over a valid/ready output channel.
- One operation is in flight at a time.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits

Ports:
CLK  input  1  clock, all state updates on rising edge
ASYNCRESETN  input  1  asynchronous active-low reset
I0  input  WIDTH  multiplicand (unsigned)
I1  input  WIDTH  multiplier (unsigned)
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
O  output  2*WIDTH  product I0*I1 (unsigned, exact, no truncation)
out_valid  output  1  O holds a completed product
out_ready  input  1  consumer accepts O

Behaviour:
- Clock and reset: one clock, CLK. Reset ASYNCRESETN is asynchronous and active-low. While it is low, every register is forced to its reset value immediately, independent of CLK.
- Reset values: state=IDLE, O=0, out_valid=0, internal count=0, multiplicand/multiplier regs=0. in_ready=1 after reset release, because in_ready = (state==IDLE).
- States (registered, 2 bits): IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture I0 into mcand (2*WIDTH bits, zero-extended), capture I1 into mplier, clear O (accumulator) to 0, clear count to 0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge: if mplier[0]=1 then O <= O + mcand, computed mod 2^(2*WIDTH); no overflow is possible.
  - Also each edge: mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
  - When count==WIDTH-1 on that edge, go to DONE.
  - I0/I1/in_valid are ignored in this state.
- DONE:
  - out_valid=1, O stable.
  - On an edge with out_ready=1, go to IDLE.
  - While out_ready=0, O and out_valid hold indefinitely.
- Latency: if acceptance happens at edge k, out_valid is high after edge k+WIDTH. It is fixed and data-independent, including zero operands; there is no early termination.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no acceptance in the DONE-to-IDLE cycle, and no back-to-back overlap.
- O after output handshake: holds the last product in IDLE until the next acceptance clears it.
- count width: clog2(WIDTH) bits, wrap-free because it is reset at each acceptance.
- Boundaries:
  - I0=0 or I1=0 -> product 0.
  - Max operands (2^WIDTH-1)^2 fit exactly in 2*WIDTH bits.
  - in_valid held high continuously -> a new operand pair is accepted only in IDLE.
- Reset mid-BUSY or mid-DONE: the operation is aborted, there is no output handshake, and the block returns to IDLE with O=0.
- Illegal state encoding (3) -> next state IDLE.

Decomposition:
- Shared package umul_pkg:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - clog2 helper function for count width
- Optional sub-module umul_step: purely combinational one-iteration step (acc, mcand, mplier -> next acc, mcand, mplier). The FSM and registers stay in umul_seq.

Test Plan:
- WIDTH=8, I0=13, I1=11, in_valid pulse at edge k, out_ready=1 -> out_valid rises after edge k+8, O=143, in_ready returns to 1 the cycle after the output handshake.
- WIDTH=8, I0=255, I1=255 -> O=65025 (0xFE01), same 8-cycle latency. Then I0=0, I1=200 -> O=0 after 8 cycles.
- WIDTH=3, I0=7, I1=7 -> O=49 after 3 cycles. I0=5, I1=3 -> O=15.
- Backpressure: product 6*7=42 complete, out_ready=0 for 5 cycles -> out_valid=1, O=42 held, in_ready=0; new in_valid with I0=1, I1=1 ignored. out_ready=1 -> IDLE, and the next operand pair yields O=1.
- Operand change during BUSY: accept I0=9, I1=9, then drive I0=3, I1=3 while BUSY -> O=81.
- Reset mid-BUSY: accept 100*100, assert ASYNCRESETN=0 between edges 3 and 4 (asynchronously) -> immediately O=0, out_valid=0, in_ready=1 after release. A following 2*3 yields 6.

Source files
------------

// File: rtl/umul_pkg.sv
// Shared definitions for the sequential unsigned multiplier.
//   state_e : FSM state encoding (IDLE=0, BUSY=1, DONE=2; 3 is illegal)
//   clog2   : ceiling log2, used to size the iteration counter
package umul_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Returns ceil(log2(value)), never less than 1 so a counter always has a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/umul_step.sv
// One shift-add iteration of the unsigned multiplier (purely combinational).
//   acc_i/acc_o       : running partial product (2*WIDTH bits)
//   mcand_i/mcand_o   : multiplicand, doubled each step (2*WIDTH bits)
//   mplier_i/mplier_o : multiplier, halved each step (WIDTH bits)
module umul_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0]   mplier_o
);

    // The sum cannot overflow: the final product always fits in 2*WIDTH bits.
    assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    assign mcand_o  = mcand_i << 1;
    assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/umul_seq.sv
// Sequential unsigned shift-add multiplier, one partial product per clock.
//   CLK, ASYNCRESETN     : clock, asynchronous active-low reset
//   I0, I1               : multiplicand / multiplier (WIDTH bits, unsigned)
//   in_valid, in_ready   : operand handshake; in_ready is high only in IDLE
//   O                    : 2*WIDTH-bit product (doubles as the accumulator)
//   out_valid, out_ready : result handshake; out_valid is high only in DONE
// Latency is fixed at WIDTH cycles from acceptance to out_valid.
module umul_seq
    import umul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    input  logic [WIDTH-1:0]   I0,
    input  logic [WIDTH-1:0]   I1,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] O,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned CntW = clog2(WIDTH);

    state_e               state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CntW-1:0]      count_q;

    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   mcand_step;
    logic [WIDTH-1:0]     mplier_step;

    umul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (acc_step),
        .mcand_o  (mcand_step),
        .mplier_o (mplier_step)
    );

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mcand_q  <= {{WIDTH{1'b0}}, I0};
                        mplier_q <= I1;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    // No early exit on a zero multiplier: latency stays data-independent.
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_step;
                    mplier_q <= mplier_step;
                    count_q  <= count_q + CntW'(1);
                    if (count_q == CntW'(WIDTH - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign O         = acc_q;

endmodule

// File: tb/tb_umul_seq.sv
// Self-checking bench for umul_seq: a WIDTH=8 instance checked every cycle against an
// arithmetic model, plus a WIDTH=3 instance exercised with literal expectations.
module tb_umul_seq;

    logic        CLK = 1'b0;
    logic        ASYNCRESETN = 1'b0;

    logic [7:0]  I0 = '0;
    logic [7:0]  I1 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] O;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [2:0]  a3 = '0;
    logic [2:0]  b3 = '0;
    logic        v3 = 1'b0;
    logic        in_ready3;
    logic [5:0]  o3;
    logic        ov3;
    logic        ordy3 = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 CLK = ~CLK;

    umul_seq #(
        .WIDTH (8)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I0          (I0),
        .I1          (I1),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .O           (O),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    umul_seq #(
        .WIDTH (3)
    ) dut3 (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I0          (a3),
        .I1          (b3),
        .in_valid    (v3),
        .in_ready    (in_ready3),
        .O           (o3),
        .out_valid   (ov3),
        .out_ready   (ordy3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after j multiply steps the accumulator equals a * (b mod 2^j);
    // the result is presented once all 8 bits of b have been consumed.
    bit              m_idle  = 1'b1;
    bit              m_valid = 1'b0;
    int              m_j     = 0;
    longint unsigned m_a     = 0;
    longint unsigned m_b     = 0;
    longint unsigned m_o     = 0;

    always @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_o     <= 0;
            m_j     <= 0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_a    <= longint'(I0);
                m_b    <= longint'(I1);
                m_o    <= 0;
                m_j    <= 0;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_idle  <= 1'b1;
            end
        end else begin
            m_o <= m_a * (m_b & ((64'd1 << (m_j + 1)) - 64'd1));
            m_j <= m_j + 1;
            if (m_j + 1 == 8) begin
                m_valid <= 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("in_ready", 64'(in_ready), 64'(m_idle));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("O", 64'(O), m_o & 64'hFFFF);
        end
    end

    // Issue one operation on the 8-bit DUT. Random garbage is driven on the operands
    // (and in_valid) while busy. hold = cycles of out_ready=0 once the result is valid;
    // poke = drive a 1*1 request during that hold, which must be ignored.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold,
                       input bit poke, output logic [15:0] res, output int lat);
        int n;
        @(negedge CLK);
        I0 = a;
        I1 = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
        @(negedge CLK);
        in_valid = 1'b0;
        I0 = 8'($urandom);
        I1 = 8'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(negedge CLK);
            lat++;
            if (out_valid) break;
            I0 = 8'($urandom);
            I1 = 8'($urandom);
            in_valid = 1'($urandom);
        end
        in_valid = 1'b0;
        if (lat >= 100) chk("result_timeout", 64'(lat), 64'd0);
        res = O;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                I0 = 8'd1;
                I1 = 8'd1;
                in_valid = 1'b1;
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic [5:0] exp,
                       input string name);
        int n;
        @(negedge CLK);
        chk({name, "_in_ready"}, 64'(in_ready3), 64'd1);
        a3 = a;
        b3 = b;
        v3 = 1'b1;
        @(negedge CLK);
        v3 = 1'b0;
        n = 0;
        while (!ov3 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd3);
        chk({name, "_O"}, 64'(o3), 64'(exp));
        ordy3 = 1'b1;
        @(negedge CLK);
        ordy3 = 1'b0;
    endtask

    initial begin
        logic [15:0] res;
        int          lat;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          n;

        #12;
        chk("reset_O", 64'(O), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        chk_on = 1'b1;

        op8(8'd13, 8'd11, 0, 1'b0, res, lat);
        chk("13x11_O", 64'(res), 64'd143);
        chk("13x11_latency", 64'(lat), 64'd8);

        op8(8'd255, 8'd255, 0, 1'b0, res, lat);
        chk("255x255_O", 64'(res), 64'd65025);
        chk("255x255_latency", 64'(lat), 64'd8);

        op8(8'd0, 8'd200, 0, 1'b0, res, lat);
        chk("0x200_O", 64'(res), 64'd0);
        chk("0x200_latency", 64'(lat), 64'd8);

        op8(8'd6, 8'd7, 5, 1'b1, res, lat);
        chk("6x7_held_O", 64'(res), 64'd42);
        op8(8'd1, 8'd1, 0, 1'b0, res, lat);
        chk("1x1_after_bp", 64'(res), 64'd1);

        op8(8'd9, 8'd9, 1, 1'b0, res, lat);
        chk("9x9_O", 64'(res), 64'd81);

        // Reset in the middle of a 100*100 computation.
        @(negedge CLK);
        I0 = 8'd100;
        I1 = 8'd100;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("100x100_partial3", 64'(O), 64'd400);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("midreset_O", 64'(O), 64'd0);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);

        op8(8'd2, 8'd3, 0, 1'b0, res, lat);
        chk("2x3_after_reset", 64'(res), 64'd6);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, int'($urandom_range(0, 3)), 1'($urandom), res, lat);
            chk("rand_product", 64'(res), 64'(ra) * 64'(rb));
            chk("rand_latency", 64'(lat), 64'd8);
        end

        op3(3'd7, 3'd7, 6'd49, "w3_7x7");
        op3(3'd5, 3'd3, 6'd15, "w3_5x3");

        repeat (2) @(negedge CLK);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
